// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: 3-bit symbols in through a small FIFO, prefix codes
// out MSB-first on x, one bit per clock, gapless between back-to-back codes.
module huffman_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       y,
    input  logic             y_valid,
    output logic             y_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      sreg, sreg_nxt;
    logic [2:0]      rem, rem_nxt;
    logic            x_nxt;

    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic            hs, sym_ok, fifo_empty, retire, can_load;
    logic            load_fifo, load_bypass, push, pop;
    logic [2:0]      load_sym;
    logic [6:0]      ld;
    logic [2:0]      ld_len;
    logic [3:0]      ld_code;

    // {length, code left-aligned in 4 bits}; must match the decoder's tree.
    function automatic logic [6:0] code_of(input logic [2:0] s);
        logic [6:0] r;
        r = '0;
        case (s)
            3'd1:    r = {3'd1, 4'b0000};
            3'd2:    r = {3'd3, 4'b1010};
            3'd3:    r = {3'd3, 4'b1000};
            3'd4:    r = {3'd3, 4'b1110};
            3'd5:    r = {3'd4, 4'b1101};
            3'd6:    r = {3'd4, 4'b1100};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign y_ready    = (count != CNT_FULL);
    assign fifo_empty = (count == '0);
    assign x_valid    = (state == S_SHIFT);
    assign busy       = (state == S_SHIFT) || !fifo_empty;

    assign hs          = y_valid && y_ready;
    assign sym_ok      = (y != 3'd0) && (y != 3'd7);
    assign retire      = (state == S_SHIFT) && (rem == '0);
    assign can_load    = (state == S_IDLE) || retire;
    assign load_fifo   = can_load && !fifo_empty;
    // An empty FIFO lets the incoming symbol go straight to the shifter.
    assign load_bypass = can_load && fifo_empty && hs && sym_ok;
    assign push        = hs && sym_ok && !load_bypass;
    assign pop         = load_fifo;
    assign load_sym    = load_fifo ? mem[rd_ptr] : y;
    assign ld          = code_of(load_sym);
    assign ld_len      = ld[6:4];
    assign ld_code     = ld[3:0];

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        rem_nxt   = rem;
        x_nxt     = x;
        if (load_fifo || load_bypass) begin
            state_nxt = S_SHIFT;
            x_nxt     = ld_code[3];
            sreg_nxt  = {ld_code[2:0], 1'b0};
            rem_nxt   = ld_len - 3'd1;
        end else if (retire) begin
            state_nxt = S_IDLE;
            x_nxt     = 1'b0;
            sreg_nxt  = '0;
            rem_nxt   = '0;
        end else if (state == S_SHIFT) begin
            x_nxt     = sreg[3];
            sreg_nxt  = {sreg[2:0], 1'b0};
            rem_nxt   = rem - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            x       <= 1'b0;
            sreg    <= '0;
            rem     <= '0;
            err     <= 1'b0;
            sym_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            sreg  <= sreg_nxt;
            rem   <= rem_nxt;
            err   <= hs && !sym_ok;
            if (retire)
                sym_cnt <= sym_cnt + CNT_W'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= y;
    end

endmodule
